// File: rtl/lcd_canvas_streamer_pkg.sv
// lcd_pkg: shared constants and types for the LCD canvas streamer.
// Holds the LCD write-window geometry, the canvas side length, the three
// RGB565 colours and the 3-bit FSM state encoding used by the streamer.
package lcd_pkg;

  localparam int WIN_W      = 160;
  localparam int WIN_H      = 144;
  localparam int CANVAS_DIM = 28;

  localparam logic [15:0] FG_COLOR     = 16'hFFFF;
  localparam logic [15:0] BG_COLOR     = 16'h0000;
  localparam logic [15:0] BORDER_COLOR = 16'h39E7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MEMWAIT,
    PRESENT,
    ACK,
    ADVANCE
  } state_t;

endpackage

// File: rtl/lcd_canvas_streamer_if.sv
// lcd_canvas_streamer_if: LT24 driver handshake plus canvas RAM read port.
// Signals:
//   lcd_initialized - driver init complete (driver -> streamer)
//   lcd_done        - driver done flag, low while a write is in flight
//   lcd_print       - write request (streamer -> driver)
//   lcd_pixel_rgb   - RGB565 pixel, stable while lcd_print is high
//   canvas_addr     - canvas RAM address (streamer -> RAM)
//   canvas_rd_data  - canvas bit, valid one cycle after canvas_addr
// Modports: master = streamer side, slave = driver/RAM side.
interface lcd_canvas_streamer_if;

  logic        lcd_initialized;
  logic        lcd_done;
  logic        lcd_print;
  logic [15:0] lcd_pixel_rgb;
  logic [9:0]  canvas_addr;
  logic        canvas_rd_data;

  modport master (
    input  lcd_initialized, lcd_done, canvas_rd_data,
    output lcd_print, lcd_pixel_rgb, canvas_addr
  );

  modport slave (
    output lcd_initialized, lcd_done, canvas_rd_data,
    input  lcd_print, lcd_pixel_rgb, canvas_addr
  );

endinterface

// File: rtl/lcd_canvas_streamer_scale_addr_gen.sv
// lcd_scale_addr_gen: raster position and upscaled canvas address counters.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   step         - advance to the next window pixel
//   clear        - return all counters to the first pixel
//   canvas_addr  - row_base + cx for the current pixel (0..783)
//   in_canvas    - current pixel lies inside the scaled canvas
//   last_pixel   - current pixel is the bottom-right window pixel
// The canvas address is built incrementally: sx/sy count LCD pixels inside
// one cell, cx/cy count cells, row_base tracks cy*CANVAS_DIM.
module lcd_scale_addr_gen
  import lcd_pkg::*;
#(
  parameter int SCALE = 5,
  parameter int X_OFF = 10,
  parameter int Y_OFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       clear,
  output logic [9:0] canvas_addr,
  output logic       in_canvas,
  output logic       last_pixel
);

  localparam int SPAN = CANVAS_DIM * SCALE;

  localparam logic [7:0] X_LO      = 8'(X_OFF);
  localparam logic [7:0] X_HI      = 8'(X_OFF + SPAN);
  localparam logic [7:0] Y_LO      = 8'(Y_OFF);
  localparam logic [7:0] Y_HI      = 8'(Y_OFF + SPAN);
  localparam logic [7:0] X_LAST    = 8'(WIN_W - 1);
  localparam logic [7:0] Y_LAST    = 8'(WIN_H - 1);
  localparam logic [2:0] SUB_LAST  = 3'(SCALE - 1);
  localparam logic [4:0] CELL_LAST = 5'(CANVAS_DIM - 1);
  localparam logic [9:0] ROW_STEP  = 10'(CANVAS_DIM);

  logic [7:0] x, y;
  logic [2:0] sx, sy;
  logic [4:0] cx, cy;
  logic [9:0] row_base;
  logic       x_in, y_in;

  assign x_in        = (x >= X_LO) && (x < X_HI);
  assign y_in        = (y >= Y_LO) && (y < Y_HI);
  assign in_canvas   = x_in && y_in;
  assign last_pixel  = (x == X_LAST) && (y == Y_LAST);
  assign canvas_addr = row_base + {5'd0, cx};

  // Cell counters saturate at the last cell, so stepping off the right or
  // bottom canvas edge leaves the address parked at the last valid cell
  // instead of running past 783.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x        <= '0;
      y        <= '0;
      sx       <= '0;
      sy       <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
    end else if (step) begin
      if (x == X_LAST) begin
        x  <= '0;
        sx <= '0;
        cx <= '0;
        y  <= (y == Y_LAST) ? 8'd0 : y + 8'd1;
        if (y_in) begin
          if (sy == SUB_LAST) begin
            sy <= '0;
            if (cy != CELL_LAST) begin
              cy       <= cy + 5'd1;
              row_base <= row_base + ROW_STEP;
            end
          end else begin
            sy <= sy + 3'd1;
          end
        end
      end else begin
        x <= x + 8'd1;
        if (x_in) begin
          if (sx == SUB_LAST) begin
            sx <= '0;
            if (cx != CELL_LAST) begin
              cx <= cx + 5'd1;
            end
          end else begin
            sx <= sx + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lcd_canvas_streamer.sv
// lcd_canvas_streamer: raster-scans the 160x144 LT24 write window and feeds
// one RGB565 pixel per driver handshake, upscaling a 28x28 1-bit canvas.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - 1-cycle pulse, stream one full frame
//   busy        - frame in progress
//   frame_done  - 1-cycle pulse after the last pixel is acknowledged
//   bus         - driver handshake and canvas RAM port (master modport)
module lcd_canvas_streamer
  import lcd_pkg::*;
#(
  parameter int SCALE = 5,
  parameter int X_OFF = 10,
  parameter int Y_OFF = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  lcd_canvas_streamer_if.master bus
);

  state_t      state, next_state;
  logic        step, clear;
  logic        in_canvas, last_pixel;
  logic        print;
  logic [15:0] pixel_q;
  logic [9:0]  addr;

  lcd_scale_addr_gen #(
    .SCALE (SCALE),
    .X_OFF (X_OFF),
    .Y_OFF (Y_OFF)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .clear       (clear),
    .canvas_addr (addr),
    .in_canvas   (in_canvas),
    .last_pixel  (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // PRESENT only moves on when the driver took the write while we were
  // actually requesting it, so a stall with lcd_initialized low never
  // loses the pixel.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && bus.lcd_initialized) next_state = FETCH;
      FETCH:   next_state = MEMWAIT;
      MEMWAIT: next_state = PRESENT;
      PRESENT: if (bus.lcd_initialized && !bus.lcd_done) next_state = ACK;
      ACK:     if (bus.lcd_done) next_state = ADVANCE;
      ADVANCE: next_state = last_pixel ? IDLE : FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    print      = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        clear = start && bus.lcd_initialized;
      end
      PRESENT: print = bus.lcd_initialized;
      ACK:     print = 1'b1;
      ADVANCE: begin
        step       = 1'b1;
        frame_done = last_pixel;
      end
      default: ;
    endcase
  end

  // Canvas data arrives during MEMWAIT (address was stable since FETCH);
  // the colour is latched here and held until the next pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_q <= '0;
    end else if (state == MEMWAIT) begin
      if (!in_canvas) begin
        pixel_q <= BORDER_COLOR;
      end else begin
        pixel_q <= bus.canvas_rd_data ? FG_COLOR : BG_COLOR;
      end
    end
  end

  assign bus.lcd_print     = print;
  assign bus.lcd_pixel_rgb = pixel_q;
  assign bus.canvas_addr   = addr;

endmodule

// File: tb/tb_lcd_canvas_streamer.sv
// tb_lcd_canvas_streamer: scoreboard bench for lcd_canvas_streamer.
// A driver model answers each print with a done low/high pulse, a RAM model
// serves canvas bits with one cycle latency, and a monitor pops the expected
// pixel queue on every accepted write.
module tb_lcd_canvas_streamer;

  localparam int W    = 160;
  localparam int H    = 144;
  localparam int NPIX = W * H;
  localparam logic [15:0] FG     = 16'hFFFF;
  localparam logic [15:0] BG     = 16'h0000;
  localparam logic [15:0] BORDER = 16'h39E7;

  typedef struct packed {
    logic [15:0] rgb;
    logic [9:0]  addr;
    logic        chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, busy, frame_done;

  lcd_canvas_streamer_if bus();

  lcd_canvas_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic        canvas_mem [0:783];
  exp_t        sb_q [$];
  logic [15:0] cap_rgb  [0:NPIX-1];
  logic [9:0]  cap_addr [0:NPIX-1];
  int          total = 0;
  int          bad = 0;
  int          hs_count = 0;
  int          fd_count = 0;
  int          cap_base = 0;
  logic        prev_done = 1'b1;
  logic        drv_phase, drv_handled;
  exp_t        mon_e;
  int          mon_idx;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int cx, cy, a;
    e = '0;
    if (x >= 10 && x < 150 && y >= 2 && y < 142) begin
      cx    = (x - 10) / 5;
      cy    = (y - 2) / 5;
      a     = cy * 28 + cx;
      e.rgb = canvas_mem[a] ? FG : BG;
      e.addr = 10'(a);
      e.chk = 1'b1;
    end else begin
      e.rgb = BORDER;
    end
    return e;
  endfunction

  // Canvas RAM with one cycle read latency.
  always @(posedge clk) begin
    bus.canvas_rd_data <= (bus.canvas_addr < 10'd784) ? canvas_mem[bus.canvas_addr] : 1'b0;
  end

  // Driver: drop done one cycle after print, raise it a cycle later, and
  // wait for print to fall before accepting another write.
  always @(posedge clk) begin
    if (reset) begin
      bus.lcd_done <= 1'b1;
      drv_phase    <= 1'b0;
      drv_handled  <= 1'b0;
    end else if (drv_phase) begin
      bus.lcd_done <= 1'b1;
      drv_phase    <= 1'b0;
    end else if (bus.lcd_print && !drv_handled) begin
      bus.lcd_done <= 1'b0;
      drv_phase    <= 1'b1;
      drv_handled  <= 1'b1;
    end else if (!bus.lcd_print) begin
      drv_handled <= 1'b0;
    end
  end

  // Monitor: each falling lcd_done is one accepted pixel.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) fd_count++;
      if (prev_done === 1'b1 && bus.lcd_done === 1'b0) begin
        mon_idx = hs_count - cap_base;
        hs_count++;
        if (mon_idx >= 0 && mon_idx < NPIX) begin
          cap_rgb[mon_idx]  = bus.lcd_pixel_rgb;
          cap_addr[mon_idx] = bus.canvas_addr;
        end
        if (sb_q.size() == 0) begin
          check_output("sb_unexpected_pixel", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check_output("pixel_rgb", 32'(bus.lcd_pixel_rgb), 32'(mon_e.rgb));
          if (mon_e.chk) check_output("pixel_addr", 32'(bus.canvas_addr), 32'(mon_e.addr));
          check_output("print_during_write", 32'(bus.lcd_print), 32'd1);
        end
      end
    end
    prev_done = bus.lcd_done;
  end

  task automatic apply_stimulus();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_pixels(input int n, input string name);
    int c = 0;
    while ((hs_count - cap_base) < n && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check_output(name, 32'((hs_count - cap_base) >= n), 32'd1);
  endtask

  initial begin
    int c;
    int fd_before;
    logic last_print;
    reset = 1'b1;
    start = 1'b0;
    bus.lcd_initialized = 1'b0;
    for (int i = 0; i < 784; i++) canvas_mem[i] = 1'b0;
    canvas_mem[0] = 1'b1;

    repeat (3) @(negedge clk);
    check_output("reset_print", 32'(bus.lcd_print), 32'd0);
    check_output("reset_rgb", 32'(bus.lcd_pixel_rgb), 32'd0);
    check_output("reset_addr", 32'(bus.canvas_addr), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    // start is ignored until the driver reports initialisation
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("start_uninit_busy", 32'(busy), 32'd0);
    bus.lcd_initialized = 1'b1;

    // full frame with a start pulse while busy and a 20 cycle stall
    $display("[TB] full frame");
    cap_base  = hs_count;
    fd_before = fd_count;
    apply_stimulus();
    wait_pixels(100, "reach_pixel_100");
    check_output("busy_midframe", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    c = 0;
    last_print = bus.lcd_print;
    while (!(bus.lcd_print && !last_print && (hs_count - cap_base) == 334) && c < 20000) begin
      last_print = bus.lcd_print;
      @(negedge clk);
      c++;
    end
    check_output("reach_stall_pixel", 32'(c < 20000), 32'd1);
    bus.lcd_initialized = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_output("stall_print", 32'(bus.lcd_print), 32'd0);
    end
    check_output("stall_no_accept", 32'(hs_count - cap_base), 32'd334);
    bus.lcd_initialized = 1'b1;

    c = 0;
    while (fd_count == fd_before && c < 200000) begin
      @(negedge clk);
      c++;
    end
    check_output("frame_done_seen", 32'(fd_count > fd_before), 32'd1);
    repeat (3) @(negedge clk);
    check_output("frame_pixels", 32'(hs_count - cap_base), 32'(NPIX));
    check_output("frame_done_pulses", 32'(fd_count - fd_before), 32'd1);
    check_output("busy_after_frame", 32'(busy), 32'd0);
    check_output("sb_empty", 32'(sb_q.size()), 32'd0);

    for (int y = 2; y <= 6; y++)
      for (int x = 10; x <= 14; x++)
        check_output("cell00_fg", 32'(cap_rgb[y * W + x]), 32'hFFFF);
    check_output("pix_15_2_bg", 32'(cap_rgb[2 * W + 15]), 32'h0000);
    check_output("pix_0_0_border", 32'(cap_rgb[0]), 32'h39E7);
    check_output("addr_149_141", 32'(cap_addr[141 * W + 149]), 32'd783);
    check_output("addr_150_141", 32'(cap_addr[141 * W + 150]), 32'd783);
    check_output("rgb_150_141", 32'(cap_rgb[141 * W + 150]), 32'h39E7);

    // reset in the middle of a frame
    $display("[TB] mid-frame reset");
    cap_base  = hs_count;
    fd_before = fd_count;
    apply_stimulus();
    wait_pixels(1000, "reach_pixel_1000");
    reset = 1'b1;
    @(negedge clk);
    check_output("midreset_print", 32'(bus.lcd_print), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    sb_q.delete();
    repeat (5) @(negedge clk);
    check_output("midreset_no_frame_done", 32'(fd_count - fd_before), 32'd0);
    check_output("midreset_idle", 32'(busy), 32'd0);

    // new frame must restart at pixel (0,0)
    $display("[TB] replay after reset");
    cap_base = hs_count;
    apply_stimulus();
    wait_pixels(400, "replay_reach_400");
    check_output("replay_pix_0_0", 32'(cap_rgb[0]), 32'h39E7);
    check_output("replay_pix_10_2", 32'(cap_rgb[2 * W + 10]), 32'hFFFF);
    check_output("replay_addr_10_2", 32'(cap_addr[2 * W + 10]), 32'd0);
    check_output("replay_pix_15_2", 32'(cap_rgb[2 * W + 15]), 32'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
